// File: rtl/draw_cmd_parser_pkg.sv
// Shared types and constants for the display-list command parser.
// - CmdCoordW       : coordinate/size field width (covers 1280x1024)
// - OP_*            : display-list opcodes, carried in word[31:24]
// - parse_state_t   : parser FSM states
// - rect_t          : rectangle {x, y, w, h}
// - op_nargs()      : argument-word count per opcode (0 for NOP/EODL/unknown)
package draw_cmd_parser_pkg;

  localparam int unsigned CmdCoordW = 11;

  localparam logic [7:0] OP_SETFRAME    = 8'h20;
  localparam logic [7:0] OP_SETDRAWAREA = 8'h21;
  localparam logic [7:0] OP_SETFCOLOR   = 8'h23;
  localparam logic [7:0] OP_PATBLT      = 8'h81;
  localparam logic [7:0] OP_EODL        = 8'h0F;
  localparam logic [7:0] OP_NOP         = 8'h00;

  typedef enum logic [2:0] {
    StIdle, StOpc, StArg, StClip, StAddr, StIssue, StWait, StFin
  } parse_state_t;

  typedef struct packed {
    logic [CmdCoordW-1:0] x;
    logic [CmdCoordW-1:0] y;
    logic [CmdCoordW-1:0] w;
    logic [CmdCoordW-1:0] h;
  } rect_t;

  function automatic logic [1:0] op_nargs(input logic [7:0] op);
    case (op)
      OP_SETFRAME, OP_SETDRAWAREA, OP_PATBLT: op_nargs = 2'd2;
      OP_SETFCOLOR:                           op_nargs = 2'd1;
      default:                                op_nargs = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/draw_cmd_parser_if.sv
// Command-FIFO and fill-engine bus of the display-list parser.
// - cmd_data/cmd_valid/cmd_ready : show-ahead FIFO head and pop
// - fill_valid/fill_ready        : rectangle request handshake
// - fill_addr/sizex/sizey/pitch/color : clipped rectangle request
// - fill_done                    : pulse when the accepted rectangle is written
// master = parser side, slave = FIFO/fill-engine side.
interface draw_cmd_parser_if
  import draw_cmd_parser_pkg::*;
#(
  parameter int unsigned CW = CmdCoordW,
  parameter int unsigned AW = 32
);
  logic [31:0]   cmd_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          fill_valid;
  logic          fill_ready;
  logic [AW-1:0] fill_addr;
  logic [CW-1:0] fill_sizex;
  logic [CW-1:0] fill_sizey;
  logic [CW+1:0] fill_pitch;
  logic [23:0]   fill_color;
  logic          fill_done;

  modport master (
    input  cmd_data, cmd_valid, fill_ready, fill_done,
    output cmd_ready, fill_valid, fill_addr, fill_sizex, fill_sizey, fill_pitch, fill_color
  );

  modport slave (
    output cmd_data, cmd_valid, fill_ready, fill_done,
    input  cmd_ready, fill_valid, fill_addr, fill_sizex, fill_sizey, fill_pitch, fill_color
  );
endinterface

// File: rtl/draw_cmd_parser_clip.sv
// Registered rectangle intersection (the CLIP stage).
// - clk_i, rst_i         : clock, synchronous active-high reset
// - load_i               : capture a new result (last PATBLT argument)
// - rect_i, area_i       : PATBLT rectangle and draw area
// - frame_w_i, frame_h_i : frame size
// - x0_o, y0_o, w_o, h_o : clipped rectangle; w/h are 0 when empty
// - empty_o              : nothing left after clipping
module draw_cmd_parser_clip
  import draw_cmd_parser_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  rect_t                rect_i,
  input  rect_t                area_i,
  input  logic [CmdCoordW-1:0] frame_w_i,
  input  logic [CmdCoordW-1:0] frame_h_i,
  output logic [CmdCoordW-1:0] x0_o,
  output logic [CmdCoordW-1:0] y0_o,
  output logic [CmdCoordW-1:0] w_o,
  output logic [CmdCoordW-1:0] h_o,
  output logic                 empty_o
);
  // One extra bit so far edges never wrap.
  localparam int unsigned SW = CmdCoordW + 1;
  typedef logic [SW-1:0] sum_t;

  function automatic sum_t min3(input sum_t a, input sum_t b, input sum_t c);
    sum_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  logic [CmdCoordW-1:0] x0_c, y0_c, w_c, h_c;
  sum_t                 x1_c, y1_c;
  logic                 empty_c;
  logic [CmdCoordW-1:0] x0_q, y0_q, w_q, h_q;
  logic                 empty_q;

  always_comb begin
    x0_c    = (rect_i.x > area_i.x) ? rect_i.x : area_i.x;
    y0_c    = (rect_i.y > area_i.y) ? rect_i.y : area_i.y;
    x1_c    = min3(SW'(rect_i.x) + SW'(rect_i.w), SW'(area_i.x) + SW'(area_i.w), SW'(frame_w_i));
    y1_c    = min3(SW'(rect_i.y) + SW'(rect_i.h), SW'(area_i.y) + SW'(area_i.h), SW'(frame_h_i));
    empty_c = (x1_c <= SW'(x0_c)) || (y1_c <= SW'(y0_c));
    // Non-empty implies x1 <= frame width, so the difference fits CmdCoordW bits.
    w_c     = empty_c ? '0 : CmdCoordW'(x1_c - SW'(x0_c));
    h_c     = empty_c ? '0 : CmdCoordW'(y1_c - SW'(y0_c));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      empty_q <= 1'b0;
    end else if (load_i) begin
      x0_q    <= x0_c;
      y0_q    <= y0_c;
      w_q     <= w_c;
      h_q     <= h_c;
      empty_q <= empty_c;
    end
  end

  assign x0_o    = x0_q;
  assign y0_o    = y0_q;
  assign w_o     = w_q;
  assign h_o     = h_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/draw_cmd_parser.sv
// Display-list command parser: pops words from the DRAWCMD FIFO, decodes
// SETFRAME/SETDRAWAREA/SETFCOLOR/PATBLT/EODL/NOP, clips each PATBLT against the
// draw area and frame, and issues one rectangle at a time to the fill engine.
// - ACLK, ARST        : clock, synchronous active-high reset
// - start             : DRAWCTRL[0] write pulse; ignored while busy
// - busy              : list being executed
// - err               : sticky unknown-opcode flag, cleared by start
// - DRW_IRQ           : one-cycle pulse at end of list or on error
// - bus (master)      : command FIFO and fill-engine handshakes
module draw_cmd_parser
  import draw_cmd_parser_pkg::*;
#(
  parameter int unsigned CW = CmdCoordW,
  parameter int unsigned AW = 32
) (
  input  logic ACLK,
  input  logic ARST,
  input  logic start,
  output logic busy,
  output logic err,
  output logic DRW_IRQ,
  draw_cmd_parser_if.master bus
);
  parse_state_t  state_q, state_d;
  logic [7:0]    opcode, op_q;
  logic [1:0]    arg_cnt_q;
  logic [31:0]   arg1_q;
  logic          op_bad, arg_xfer, arg_last, clip_load;
  logic [CW-1:0] cmd_hi, cmd_lo, arg1_hi, arg1_lo;
  logic [AW-1:0] vram_q, addr_q, pix_idx;
  logic [CW-1:0] fw_q, fh_q;
  rect_t         area_q, blt_rect;
  logic [23:0]   color_q;
  logic          err_q;
  logic [CW-1:0] clip_x0, clip_y0, clip_w, clip_h;
  logic          clip_empty;

  assign opcode   = bus.cmd_data[31:24];
  assign cmd_hi   = bus.cmd_data[16 +: CW];
  assign cmd_lo   = bus.cmd_data[0 +: CW];
  assign arg1_hi  = arg1_q[16 +: CW];
  assign arg1_lo  = arg1_q[0 +: CW];
  assign op_bad   = (op_nargs(opcode) == 2'd0) && (opcode != OP_NOP) && (opcode != OP_EODL);
  assign arg_xfer = (state_q == StArg) && bus.cmd_valid;
  assign arg_last = arg_xfer && ((arg_cnt_q + 2'd1) == op_nargs(op_q));
  assign clip_load = arg_last && (op_q == OP_PATBLT);
  // Clip inputs are taken straight from the transferring word so the CLIP
  // state already sees the registered intersection.
  assign blt_rect = rect_t'{x: arg1_hi, y: arg1_lo, w: cmd_hi, h: cmd_lo};
  assign pix_idx  = AW'(clip_y0) * AW'(fw_q) + AW'(clip_x0);

  draw_cmd_parser_clip u_clip (
    .clk_i     (ACLK),
    .rst_i     (ARST),
    .load_i    (clip_load),
    .rect_i    (blt_rect),
    .area_i    (area_q),
    .frame_w_i (fw_q),
    .frame_h_i (fh_q),
    .x0_o      (clip_x0),
    .y0_o      (clip_y0),
    .w_o       (clip_w),
    .h_o       (clip_h),
    .empty_o   (clip_empty)
  );

  always_ff @(posedge ACLK) begin
    if (ARST) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StOpc;
      StOpc: begin
        if (bus.cmd_valid) begin
          if (op_nargs(opcode) != 2'd0) state_d = StArg;
          else if (opcode != OP_NOP)    state_d = StFin;  // EODL or unknown
        end
      end
      StArg:   if (arg_last) state_d = (op_q == OP_PATBLT) ? StClip : StOpc;
      StClip:  state_d = clip_empty ? StOpc : StAddr;
      StAddr:  state_d = StIssue;
      StIssue: if (bus.fill_ready) state_d = StWait;
      StWait:  if (bus.fill_done) state_d = StOpc;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.cmd_ready  = 1'b0;
    bus.fill_valid = 1'b0;
    busy           = 1'b0;
    DRW_IRQ        = 1'b0;
    unique case (state_q)
      StOpc, StArg: begin
        bus.cmd_ready = 1'b1;
        busy          = 1'b1;
      end
      StClip, StAddr, StWait: busy = 1'b1;
      StIssue: begin
        bus.fill_valid = 1'b1;
        busy           = 1'b1;
      end
      StFin:   DRW_IRQ = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      op_q      <= '0;
      arg_cnt_q <= '0;
      arg1_q    <= '0;
      vram_q    <= '0;
      fw_q      <= '0;
      fh_q      <= '0;
      area_q    <= '0;
      color_q   <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      if ((state_q == StIdle) && start) err_q <= 1'b0;
      if ((state_q == StOpc) && bus.cmd_valid) begin
        op_q      <= opcode;
        arg_cnt_q <= '0;
        if (op_bad) err_q <= 1'b1;
      end
      if (arg_xfer) begin
        arg_cnt_q <= arg_cnt_q + 2'd1;
        if (arg_cnt_q == 2'd0) arg1_q <= bus.cmd_data;
        if (arg_last) begin
          case (op_q)
            OP_SETFRAME: begin
              vram_q <= AW'(arg1_q);
              fw_q   <= cmd_hi;
              fh_q   <= cmd_lo;
            end
            OP_SETDRAWAREA: area_q  <= rect_t'{x: arg1_hi, y: arg1_lo, w: cmd_hi, h: cmd_lo};
            OP_SETFCOLOR:   color_q <= bus.cmd_data[23:0];
            default: ;
          endcase
        end
      end
      if (state_q == StAddr) addr_q <= vram_q + (pix_idx << 2);
    end
  end

  assign err            = err_q;
  assign bus.fill_addr  = addr_q;
  assign bus.fill_sizex = clip_w;
  assign bus.fill_sizey = clip_h;
  assign bus.fill_pitch = {fw_q, 2'b00};
  assign bus.fill_color = color_q;
endmodule

// File: tb/tb_draw_cmd_parser.sv
module tb_draw_cmd_parser;
  import draw_cmd_parser_pkg::*;

  logic clk;
  logic ARST, start, busy, err, DRW_IRQ;

  draw_cmd_parser_if bus ();

  draw_cmd_parser dut (
    .ACLK    (clk),
    .ARST    (ARST),
    .start   (start),
    .busy    (busy),
    .err     (err),
    .DRW_IRQ (DRW_IRQ),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          sx;
    int          sy;
    int          pitch;
    logic [23:0] color;
  } fill_t;

  fill_t       exp_fill[$];
  logic        exp_irq[$];
  logic [31:0] fifo[$];

  int checks = 0, errors = 0, irq_count = 0, fill_accepts = 0;
  bit in_run = 0, hold_done = 0, drop_done = 0;
  int stall_left = 0;

  // Reference model state (what the registers should hold).
  logic [31:0] m_vram;
  int m_fw, m_fh, m_ax, m_ay, m_aw, m_ah;
  logic [23:0] m_color;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_vram = 0; m_fw = 0; m_fh = 0; m_ax = 0; m_ay = 0; m_aw = 0; m_ah = 0; m_color = 0;
  endtask

  function automatic logic [31:0] pair(input int hi, input int lo);
    logic [31:0] w;
    w = $urandom;  // junk above the fields
    w[26:16] = hi[10:0];
    w[10:0]  = lo[10:0];
    return w;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic c_frame(input logic [31:0] vram, input int fw, input int fh);
    fifo.push_back({OP_SETFRAME, 24'h0});
    fifo.push_back(vram);
    fifo.push_back(pair(fw, fh));
    m_vram = vram; m_fw = fw; m_fh = fh;
  endtask

  task automatic c_area(input int ax, input int ay, input int aw, input int ah);
    fifo.push_back({OP_SETDRAWAREA, 24'h0});
    fifo.push_back(pair(ax, ay));
    fifo.push_back(pair(aw, ah));
    m_ax = ax; m_ay = ay; m_aw = aw; m_ah = ah;
  endtask

  task automatic c_color(input logic [23:0] c);
    fifo.push_back({OP_SETFCOLOR, 24'h0});
    fifo.push_back({8'($urandom), c});
    m_color = c;
  endtask

  task automatic c_patblt(input int px, input int py, input int sx, input int sy);
    int x0, x1, y0, y1;
    fill_t f;
    fifo.push_back({OP_PATBLT, 24'h0});
    fifo.push_back(pair(px, py));
    fifo.push_back(pair(sx, sy));
    x0 = imax(px, m_ax);
    y0 = imax(py, m_ay);
    x1 = imin(imin(px + sx, m_ax + m_aw), m_fw);
    y1 = imin(imin(py + sy, m_ay + m_ah), m_fh);
    if (x1 > x0 && y1 > y0) begin
      f.addr  = m_vram + 32'((y0 * m_fw + x0) * 4);
      f.sx    = x1 - x0;
      f.sy    = y1 - y0;
      f.pitch = m_fw * 4;
      f.color = m_color;
      exp_fill.push_back(f);
    end
  endtask

  task automatic c_nop();
    fifo.push_back({OP_NOP, 24'h0});
  endtask

  task automatic c_eodl();
    fifo.push_back({OP_EODL, 24'h0});
    exp_irq.push_back(1'b0);
  endtask

  task automatic c_bad(input logic [7:0] op);
    fifo.push_back({op, 24'h0});
    exp_irq.push_back(1'b1);
  endtask

  task automatic run_list(input string name);
    int base, n;
    base = irq_count;
    n = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_run = 1'b1;
    @(negedge clk);
    chk({name, "_err_clr"}, 32'(err), 32'd0);
    while (irq_count == base && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (irq_count == base) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no DRW_IRQ, required one within 20000 cycles", name);
      in_run = 1'b0;
    end
    @(negedge clk);
  endtask

  // Command FIFO: show-ahead head with random empty gaps.
  initial begin
    bit xfer;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    forever begin
      @(negedge clk);
      xfer = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk); #1;
      if (xfer && fifo.size() > 0) fifo.delete(0);
      if (stall_left > 0) stall_left--;
      else if ($urandom_range(0, 5) == 0) stall_left = $urandom_range(1, 6);
      bus.cmd_valid = (fifo.size() > 0) && (stall_left == 0);
      bus.cmd_data  = (fifo.size() > 0) ? fifo[0] : 32'h0;
    end
  end

  // Fill engine: random ready delay, random completion delay.
  initial begin
    bus.fill_ready = 1'b0;
    bus.fill_done  = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.fill_done = 1'b0;
      if (bus.fill_valid) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        bus.fill_ready = 1'b1;
        @(posedge clk); #1;
        bus.fill_ready = 1'b0;
        repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
        while (hold_done) begin @(posedge clk); #1; end
        if (drop_done) drop_done = 1'b0;
        else           bus.fill_done = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted request and every IRQ.
  initial begin
    fill_t f;
    logic  e;
    forever begin
      @(negedge clk);
      if (!ARST) begin
        if (bus.fill_valid && bus.fill_ready) begin
          fill_accepts++;
          if (exp_fill.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fill: got request addr=%h size=%0dx%0d, required none",
                     bus.fill_addr, bus.fill_sizex, bus.fill_sizey);
          end else begin
            f = exp_fill.pop_front();
            chk("fill_addr", bus.fill_addr, f.addr);
            chk("fill_sizex", 32'(bus.fill_sizex), f.sx);
            chk("fill_sizey", 32'(bus.fill_sizey), f.sy);
            chk("fill_pitch", 32'(bus.fill_pitch), f.pitch);
            chk("fill_color", 32'(bus.fill_color), 32'(f.color));
          end
        end
        if (DRW_IRQ) begin
          irq_count++;
          in_run = 1'b0;
          if (exp_irq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_irq: got DRW_IRQ, required none");
          end else begin
            e = exp_irq.pop_front();
            chk("irq_err", 32'(err), 32'(e));
            chk("irq_busy", 32'(busy), 32'd0);
          end
        end else if (in_run) begin
          chk("busy_hold", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_err"}, 32'(err), 0);
    chk({name, "_irq"}, 32'(DRW_IRQ), 0);
    chk({name, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
    chk({name, "_fill_valid"}, 32'(bus.fill_valid), 0);
    chk({name, "_fill_addr"}, bus.fill_addr, 0);
    chk({name, "_fill_sizex"}, 32'(bus.fill_sizex), 0);
    chk({name, "_fill_sizey"}, 32'(bus.fill_sizey), 0);
    chk({name, "_fill_pitch"}, 32'(bus.fill_pitch), 0);
    chk({name, "_fill_color"}, 32'(bus.fill_color), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, required finish before 900000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, np;
    ARST  = 1'b1;
    start = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 ARST = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // Full fill
    c_frame(32'h2000_0000, 640, 480);
    c_area(0, 0, 640, 480);
    c_color(24'hFF0000);
    c_patblt(0, 0, 640, 480);
    c_eodl();
    run_list("full");

    // Inner rect, registers retained from the previous list
    c_patblt(160, 120, 320, 240);
    c_eodl();
    run_list("inner");

    // Area clip
    c_area(160, 120, 320, 240);
    c_color(24'h0000FF);
    c_patblt(0, 0, 640, 480);
    c_eodl();
    run_list("area");

    // Frame clip
    c_area(0, 0, 640, 480);
    c_patblt(480, 360, 320, 240);
    c_eodl();
    run_list("frame");

    // Degenerate rectangles give no request but still an IRQ
    c_patblt(700, 0, 10, 10);
    c_nop();
    c_patblt(0, 0, 0, 5);
    c_eodl();
    run_list("degen");

    // Unknown opcode
    c_nop();
    c_bad(8'h55);
    run_list("badop");
    chk("err_sticky", 32'(err), 32'd1);
    chk("badop_busy", 32'(busy), 32'd0);

    // Randomised lists
    for (int r = 0; r < 10; r++) begin
      c_area($urandom_range(0, 600), $urandom_range(0, 450),
             $urandom_range(0, 700), $urandom_range(0, 500));
      c_color(24'($urandom));
      np = $urandom_range(1, 4);
      for (int k = 0; k < np; k++) begin
        if ($urandom_range(0, 3) == 0) c_nop();
        c_patblt($urandom_range(0, 700), $urandom_range(0, 520),
                 $urandom_range(0, 700), $urandom_range(0, 520));
      end
      if (r == 7) c_bad(8'h40 + 8'($urandom_range(0, 15)));
      else        c_eodl();
      run_list("rand");
    end

    // Reset while a fill is outstanding, then a normal re-run
    hold_done = 1'b1;
    c_area(0, 0, 640, 480);
    c_patblt(10, 20, 30, 40);
    c_eodl();
    base = fill_accepts;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_run = 1'b1;
    n = 0;
    while (fill_accepts == base && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    if (fill_accepts == base) begin
      checks++;
      errors++;
      $display("FAIL arst_wait_timeout: got no fill request, required one within 20000 cycles");
    end
    @(posedge clk); #1;
    in_run = 1'b0;
    ARST = 1'b1;
    @(posedge clk); #1;
    ARST = 1'b0;
    fifo.delete();
    exp_irq.delete();
    exp_fill.delete();
    model_reset();
    drop_done = 1'b1;
    hold_done = 1'b0;
    @(negedge clk);
    chk_all_zero("arst");
    repeat (12) @(posedge clk);
    #1;
    c_frame(32'h2000_0000, 640, 480);
    c_area(0, 0, 640, 480);
    c_color(24'hFF0000);
    c_patblt(0, 0, 640, 480);
    c_eodl();
    run_list("rerun");

    chk("fills_left", 32'(exp_fill.size()), 32'd0);
    chk("irqs_left", 32'(exp_irq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
